accumulator_16bit: RTL and testbench
====================================

# accumulator_16bit

Registered 16-bit running-sum stage wrapped around the team's combinational carry-select adder. It drives one `carryselectadder_16bit` instance with the accumulator and the incoming operand. It captures `sum`/`carry_out` each accepted beat. On request it hands a snapshot of sum, overflow and beat count downstream over a valid/ready interface.

## Interface
Parameters:
- CNT_W, default 8: width of the accepted-beat counter; the counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat.
- in_data  in  16  unsigned operand; wired to adder port `b`.
- clear  in  1  synchronous clear of the accumulation state.
- dump  in  1  single-cycle request to snapshot the result and start a fresh sum.
- out_valid  out  1  snapshot is pending.
- out_ready  in  1  downstream accepts the snapshot.
- out_sum  out  16  snapshot of the accumulator.
- out_ovf  out  1  snapshot of the sticky carry-out flag.
- out_count  out  CNT_W  snapshot of the beat count.

## Operation
- Internal state:
  - acc[15:0]: drives adder port `a`.
  - ovf_sticky.
  - cnt[CNT_W-1:0].
  - rdy_q: registered ready.
  - Output register set: out_valid, out_sum, out_ovf, out_count.
- Beat accepted when `in_valid && in_ready`. On acceptance:
  - acc <= adder `sum`.
  - ovf_sticky <= ovf_sticky | `carry_out`.
  - cnt <= cnt+1, held at all-ones once reached.
- Arithmetic is unsigned modulo 2^16. `carry_out` is the only overflow indication and is never cleared except by clear, dump or reset.
- `in_ready` = rdy_q && !clear. rdy_q is 0 in reset and becomes 1 on the first clock edge after rst_n deasserts.
- Output FSM has two states, EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY -> FULL on an honoured dump.
  - FULL -> EMPTY on `out_ready` when no dump is honoured in the same cycle.
  - FULL -> FULL with new data on `out_ready` and an honoured dump in the same cycle.
- A dump is honoured only when `!clear && (!out_valid || out_ready)`. Otherwise it is dropped silently; it is not queued.
- Honoured dump:
  - The snapshot takes the post-beat values: if a beat is accepted in the same cycle, that beat is included in out_sum, out_ovf and out_count.
  - acc, ovf_sticky and cnt are then zeroed.
- Accumulation continues while in FULL. Output registers stay stable until handshaken.
- `clear` has priority over a beat and over dump in the same cycle:
  - acc, ovf_sticky and cnt <= 0.
  - No beat is accepted (in_ready=0).
  - dump is dropped.
  - Output registers are untouched.
- Reset mid-operation (any cycle): every register returns to its reset value immediately and asynchronously. A pending snapshot is lost.

## Timing
- Reset values: in_ready=0, out_valid=0, out_sum=0x0000, out_ovf=0, out_count=0. acc, ovf_sticky and cnt are also 0.
- Adder path is combinational within one cycle: acc -> adder -> acc register.
- Beat-to-acc latency: 1 cycle. Back-to-back beats are supported every cycle.
- Dump-to-out_valid latency: 1 cycle. out_valid rises on the edge that samples the honoured dump.
- Output handshake completes on the edge where out_valid && out_ready. out_valid falls that edge unless it is reloaded by an honoured dump.
- Throughput: one snapshot per cycle is possible while out_ready is held high.

## Test plan
- Reset; beats 0x0001, 0x0002, 0x0003 on consecutive cycles; dump on the next cycle -> one cycle later out_valid=1, out_sum=0x0006, out_ovf=0, out_count=3; acc reads 0.
- Beats 0xFFFF then 0x0002, then dump -> out_sum=0x0001, out_ovf=1, out_count=2. A further beat 0x0004 and dump -> out_sum=0x0004, out_ovf=0.
- acc=0x0010; beat 0x0005 with dump in the same cycle -> out_sum=0x0015 and count includes the beat. Next beat 0x0003 then dump -> out_sum=0x0003, out_count=1.
- out_ready=0 with FULL holding 0x0006:
  - Beats 0x0007 and 0x0001 are still accepted.
  - A second dump is dropped; outputs stay at 0x0006.
  - Raise out_ready together with dump -> out_sum=0x0008 on the next edge; out_valid stays 1.
- clear asserted alongside in_valid (0x0009) and dump while acc=0x0100 -> in_ready=0; acc=0, cnt=0; out_valid unchanged. A later dump yields out_sum=0x0000, out_count=0.
- CNT_W=2: five beats of 0x0001, then dump -> out_count=3 (saturated), out_sum=0x0005.
- rst_n pulsed low while out_valid=1 -> out_valid, out_sum and in_ready go to 0 without waiting for a clock edge. in_ready returns to 1 one edge after release.

Source files
------------

// File: rtl/accumulator_16bit.sv
// Registered 16-bit running-sum stage around a combinational carry-select adder.
// It captures a snapshot of sum, sticky overflow and beat count on request and hands it downstream over valid/ready.

module carryselectadder_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        carry_out
);

    // Returns {carry, sum[3:0]} of a 4-bit ripple add.
    function automatic logic [4:0] ripple4(input logic [3:0] x,
                                           input logic [3:0] y,
                                           input logic       ci);
        logic [4:0] r;
        logic       cc;
        r  = '0;
        cc = ci;
        for (int i = 0; i < 4; i++) begin
            r[i] = x[i] ^ y[i] ^ cc;
            cc   = (x[i] & y[i]) | (cc & (x[i] ^ y[i]));
        end
        r[4] = cc;
        return r;
    endfunction

    logic [4:0] pre0 [4];
    logic [4:0] pre1 [4];
    logic [4:0] c;

    assign c[0] = 1'b0;

    // Each nibble is computed for both carry-in values; the real carry only picks one.
    for (genvar g = 0; g < 4; g++) begin : g_blk
        assign pre0[g]        = ripple4(a[4*g +: 4], b[4*g +: 4], 1'b0);
        assign pre1[g]        = ripple4(a[4*g +: 4], b[4*g +: 4], 1'b1);
        assign sum[4*g +: 4]  = c[g] ? pre1[g][3:0] : pre0[g][3:0];
        assign c[g+1]         = c[g] ? pre1[g][4]   : pre0[g][4];
    end

    assign carry_out = c[4];

endmodule

module accumulator_16bit #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             clear,
    input  logic             dump,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic             out_ovf,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t           state_q, state_d;
    logic [15:0]      acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q;
    logic [15:0]      osum_q;
    logic             oovf_q;
    logic [CNT_W-1:0] ocnt_q;

    logic [15:0]      add_sum;
    logic             add_co;
    logic             beat;
    logic             dump_ok;
    logic [15:0]      acc_post;
    logic             ovf_post;
    logic [CNT_W-1:0] cnt_post;

    carryselectadder_16bit u_add (
        .a         (acc_q),
        .b         (in_data),
        .sum       (add_sum),
        .carry_out (add_co)
    );

    assign in_ready  = rdy_q && !clear;
    assign out_valid = (state_q == FULL);
    assign out_sum   = osum_q;
    assign out_ovf   = oovf_q;
    assign out_count = ocnt_q;

    assign beat    = in_valid && in_ready;
    assign dump_ok = dump && !clear && (!out_valid || out_ready);

    // Post-beat view: a snapshot taken in the same cycle as a beat includes it.
    assign acc_post = beat ? add_sum        : acc_q;
    assign ovf_post = ovf_q | (beat & add_co);
    assign cnt_post = beat ? sat_inc(cnt_q) : cnt_q;

    always_comb begin
        acc_d = acc_post;
        ovf_d = ovf_post;
        cnt_d = cnt_post;
        if (clear || dump_ok) begin
            acc_d = '0;
            ovf_d = 1'b0;
            cnt_d = '0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (dump_ok) state_d = FULL;
            FULL:    if (dump_ok) state_d = FULL;
                     else if (out_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            osum_q  <= '0;
            oovf_q  <= 1'b0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            if (dump_ok) begin
                osum_q <= acc_post;
                oovf_q <= ovf_post;
                ocnt_q <= cnt_post;
            end
        end
    end

endmodule

// File: tb/tb_accumulator_16bit.sv
// Bench for accumulator_16bit: a vector table drives the main instance and a scoreboard
// checks each handshaken snapshot; hand sequences cover counter saturation and async reset.

module tb_accumulator_16bit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, clear, dump, out_ready, in_ready, out_valid, out_ovf;
    logic [15:0] in_data, out_sum;
    logic [7:0]  out_count;

    logic        v2, clr2, dmp2, ordy2, rdy2, ovld2, oovf2;
    logic [15:0] d2, osum2;
    logic [1:0]  ocnt2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        s_ovf;
        logic [15:0] s_sum;
        logic [7:0]  s_cnt;
    } snap_t;

    typedef struct {
        logic        v;
        logic [15:0] d;
        logic        clr;
        logic        dmp;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_vld;
        logic        push;
        logic [15:0] es;
        logic        eo;
        logic [7:0]  ec;
    } vec_t;

    snap_t sb[$];
    vec_t  vecs[29];

    always #5 clk = ~clk;

    accumulator_16bit #(.CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .clear(clear), .dump(dump), .out_valid(out_valid),
        .out_ready(out_ready), .out_sum(out_sum), .out_ovf(out_ovf), .out_count(out_count)
    );

    accumulator_16bit #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(v2), .in_ready(rdy2),
        .in_data(d2), .clear(clr2), .dump(dmp2), .out_valid(ovld2),
        .out_ready(ordy2), .out_sum(osum2), .out_ovf(oovf2), .out_count(ocnt2)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic run_vec(input int idx, input vec_t t);
        logic        pv;
        logic [15:0] ps;
        logic        po;
        logic [7:0]  pc;
        snap_t       e;
        in_valid  = t.v;
        in_data   = t.d;
        clear     = t.clr;
        dump      = t.dmp;
        out_ready = t.ordy;
        #1;
        check($sformatf("in_ready[%0d]", idx), {31'd0, in_ready}, {31'd0, t.exp_rdy});
        pv = out_valid;
        ps = out_sum;
        po = out_ovf;
        pc = out_count;
        if (t.push) sb.push_back('{s_ovf: t.eo, s_sum: t.es, s_cnt: t.ec});
        @(posedge clk);
        #1;
        if (pv && t.ordy) begin
            if (sb.size() == 0) begin
                check($sformatf("sb_empty[%0d]", idx), 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check($sformatf("snap_sum[%0d]", idx), {16'd0, ps}, {16'd0, e.s_sum});
                check($sformatf("snap_ovf[%0d]", idx), {31'd0, po}, {31'd0, e.s_ovf});
                check($sformatf("snap_cnt[%0d]", idx), {24'd0, pc}, {24'd0, e.s_cnt});
            end
        end
        check($sformatf("out_valid[%0d]", idx), {31'd0, out_valid}, {31'd0, t.exp_vld});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           v     d         clr   dmp   ordy  rdy   vld   push  es        eo    ec
        vecs[0]  = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[1]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b0, 8'd3};
        vecs[4]  = '{1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[6]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b1, 8'd2};
        vecs[7]  = '{1'b1, 16'h0004, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0004, 1'b0, 8'd1};
        vecs[9]  = '{1'b1, 16'h0010, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[10] = '{1'b1, 16'h0005, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0015, 1'b0, 8'd2};
        vecs[11] = '{1'b1, 16'h0003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0003, 1'b0, 8'd1};
        vecs[13] = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 16'h0007, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[16] = '{1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0008, 1'b0, 8'd2};
        vecs[19] = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[20] = '{1'b1, 16'h0100, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h0200, 1'b0, 8'd2};
        vecs[21] = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[22] = '{1'b1, 16'h0009, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[23] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[24] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 8'd0};
        vecs[25] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};
        vecs[26] = '{1'b1, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0001, 1'b0, 8'd1};
        vecs[27] = '{1'b1, 16'h0002, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0002, 1'b0, 8'd1};
        vecs[28] = '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 8'd0};

        rst_n = 1'b0;
        in_valid = 1'b0; in_data = '0; clear = 1'b0; dump = 1'b0; out_ready = 1'b0;
        v2 = 1'b0; d2 = '0; clr2 = 1'b0; dmp2 = 1'b0; ordy2 = 1'b0;

        #12;
        check("rst_in_ready",  {31'd0, in_ready},  32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_sum",   {16'd0, out_sum},   32'd0);
        check("rst_out_ovf",   {31'd0, out_ovf},   32'd0);
        check("rst_out_count", {24'd0, out_count}, 32'd0);
        #1 rst_n = 1'b1;
        #1;
        check("rdy_before_edge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rdy_after_edge", {31'd0, in_ready}, 32'd1);

        for (int i = 0; i < 29; i++) run_vec(i, vecs[i]);
        check("sb_drained", sb.size(), 32'd0);

        // Counter saturation on the narrow-counter instance.
        v2 = 1'b1; d2 = 16'h0001;
        repeat (5) @(posedge clk);
        #1;
        v2 = 1'b0; dmp2 = 1'b1;
        @(posedge clk);
        #1;
        dmp2 = 1'b0;
        check("sat_valid", {31'd0, ovld2}, 32'd1);
        check("sat_count", {30'd0, ocnt2}, 32'd3);
        check("sat_sum",   {16'd0, osum2}, 32'h5);
        check("sat_ovf",   {31'd0, oovf2}, 32'd0);

        // Asynchronous reset while a snapshot is pending.
        in_valid = 1'b1; in_data = 16'h0055; dump = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0; dump = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        check("pre_rst_sum",   {16'd0, out_sum},   32'h55);
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid",  {31'd0, out_valid}, 32'd0);
        check("arst_sum",    {16'd0, out_sum},   32'd0);
        check("arst_ready",  {31'd0, in_ready},  32'd0);
        check("arst_count",  {24'd0, out_count}, 32'd0);
        check("arst_valid2", {31'd0, ovld2},     32'd0);
        #2 rst_n = 1'b1;
        #1;
        check("rel_ready_noedge", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_ready_edge", {31'd0, in_ready}, 32'd1);

        // Fresh sum after reset: the pre-reset 0x55 must be gone.
        in_valid = 1'b1; in_data = 16'h0002; dump = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; dump = 1'b0;
        check("post_rst_sum",   {16'd0, out_sum},   32'h2);
        check("post_rst_count", {24'd0, out_count}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
